// File: rtl/out_ram_ctrl_if.sv
// Requester/RAM bus bundle for out_ram_ctrl.
//   req0_*/req1_* : two valid/ready write requesters (32-bit words)
//   ram_*         : write port toward the 8x32 output RAM
// slave  : the controller side (accepts requests, drives the RAM port)
// master : the requester/RAM side (drives requests, observes the rest)
interface out_ram_ctrl_if;
   logic        req0_valid;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        ram_write;
   logic [2:0]  ram_addr;
   logic [31:0] ram_data;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, ram_write, ram_addr, ram_data
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, ram_write, ram_addr, ram_data
   );
endinterface

// File: rtl/out_ram_ctrl.sv
// Output RAM write controller: collects one 8-word frame from two
// requesters into an 8x32 RAM, arbitrating round-robin on ties.
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle pulse starting a new frame (ignored while busy)
//   bus      : requester handshakes and RAM write port (slave side)
//   busy     : frame in progress (RUN)
//   done     : frame complete (DONE)
//   wr_count : words accepted in the current frame, 0..8
module out_ram_ctrl (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   out_ram_ctrl_if.slave      bus,
   output logic               busy,
   output logic               done,
   output logic [3:0]         wr_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wr_count_q, wr_count_d;
   logic        last_grant_q, last_grant_d;
   logic        ram_write_q, ram_write_d;
   logic [2:0]  ram_addr_q, ram_addr_d;
   logic [31:0] ram_data_q, ram_data_d;
   logic        rdy0, rdy1;
   logic        xfer, gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_count_q   <= 4'd0;
         last_grant_q <= 1'b1;   // requester 0 wins the first tie
         ram_write_q  <= 1'b0;
         ram_addr_q   <= 3'd0;
         ram_data_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         wr_count_q   <= wr_count_d;
         last_grant_q <= last_grant_d;
         ram_write_q  <= ram_write_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_count_d   = wr_count_q;
      last_grant_d = last_grant_q;
      ram_write_d  = 1'b0;
      ram_addr_d   = ram_addr_q;   // address/data hold between writes
      ram_data_d   = ram_data_q;
      rdy0         = 1'b0;
      rdy1         = 1'b0;
      xfer         = 1'b0;
      gnt          = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               wr_count_d = 4'd0;
            end
         end
         RUN: begin
            // On a tie the requester that did not win last time goes next.
            if (bus.req0_valid && bus.req1_valid) begin
               rdy0 = last_grant_q;
               rdy1 = ~last_grant_q;
            end else begin
               rdy0 = bus.req0_valid;
               rdy1 = bus.req1_valid;
            end
            xfer = (rdy0 && bus.req0_valid) || (rdy1 && bus.req1_valid);
            gnt  = rdy1 && bus.req1_valid;
            if (xfer) begin
               ram_write_d  = 1'b1;
               ram_addr_d   = wr_count_q[2:0];
               ram_data_d   = gnt ? bus.req1_data : bus.req0_data;
               wr_count_d   = wr_count_q + 4'd1;
               last_grant_d = gnt;
               if (wr_count_q == 4'd7) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.ram_write  = ram_write_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_data   = ram_data_q;
   assign busy           = (state_q == RUN);
   assign done           = (state_q == DONE);
   assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_out_ram_ctrl.sv
module tb_out_ram_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done;
   logic [3:0] wr_count;

   out_ram_ctrl_if bus();

   out_ram_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus.slave),
      .busy     (busy),
      .done     (done),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model
   int          m_state = M_IDLE;
   logic [3:0]  m_cnt   = 4'd0;
   logic        m_last  = 1'b1;
   logic [2:0]  m_addr  = 3'd0;
   logic [31:0] m_data  = 32'd0;
   logic [34:0] exp_q[$];

   // scoreboard: each RAM write pops one expected {addr,data}
   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         if (bus.ram_write) begin
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: addr=%0d data=%h, none expected",
                        bus.ram_addr, bus.ram_data);
            end else begin
               logic [34:0] e;
               e = exp_q.pop_front();
               if ({bus.ram_addr, bus.ram_data} !== e) begin
                  fails++;
                  $display("FAIL ram_write: got addr=%0d data=%h, want addr=%0d data=%h",
                           bus.ram_addr, bus.ram_data, e[34:32], e[31:0]);
               end
               m_addr = e[34:32];
               m_data = e[31:0];
            end
         end else if ({bus.ram_addr, bus.ram_data} !== {m_addr, m_data}) begin
            fails++;
            $display("FAIL ram_hold: got addr=%0d data=%h, want addr=%0d data=%h",
                     bus.ram_addr, bus.ram_data, m_addr, m_data);
         end
      end
   end

   // One clock of stimulus; checks readies/status and advances the model.
   task automatic cycle(input logic s, input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1);
      logic er0, er1, g;
      @(negedge clk);
      start = s;
      bus.req0_valid = v0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_data = d1;
      #1;
      er0 = 1'b0; er1 = 1'b0;
      if (m_state == M_RUN) begin
         if (v0 && v1) begin er0 = m_last; er1 = ~m_last; end
         else begin er0 = v0; er1 = v1; end
      end
      tests++;
      if ({bus.req0_ready, bus.req1_ready, busy, done, wr_count} !==
          {er0, er1, m_state == M_RUN, m_state == M_DONE, m_cnt}) begin
         fails++;
         $display("FAIL status: got r0=%b r1=%b busy=%b done=%b cnt=%0d, want r0=%b r1=%b busy=%b done=%b cnt=%0d",
                  bus.req0_ready, bus.req1_ready, busy, done, wr_count,
                  er0, er1, m_state == M_RUN, m_state == M_DONE, m_cnt);
      end
      if (m_state != M_RUN) begin
         if (s) begin m_state = M_RUN; m_cnt = 4'd0; end
      end else if ((v0 && er0) || (v1 && er1)) begin
         g = v1 && er1;
         exp_q.push_back({m_cnt[2:0], g ? d1 : d0});
         m_cnt++;
         m_last = g;
         if (m_cnt == 4'd8) m_state = M_DONE;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic do_reset_async();
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #2 rst = 1'b1;
      m_state = M_IDLE; m_cnt = 4'd0; m_last = 1'b1;
      m_addr = 3'd0; m_data = 32'd0;
      exp_q.delete();
      #1;
      tests++;
      if ({bus.ram_write, bus.ram_addr, bus.ram_data, busy, done, wr_count,
           bus.req0_ready, bus.req1_ready} !== 44'd0) begin
         fails++;
         $display("FAIL async_reset: wr=%b addr=%0d data=%h busy=%b done=%b cnt=%0d r0=%b r1=%b",
                  bus.ram_write, bus.ram_addr, bus.ram_data, busy, done, wr_count,
                  bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_data = 32'd0; bus.req1_data = 32'd0;
      #1;
      tests++;
      if ({bus.ram_write, bus.ram_addr, bus.ram_data, busy, done, wr_count,
           bus.req0_ready, bus.req1_ready} !== 44'd0) begin
         fails++;
         $display("FAIL reset_state: wr=%b addr=%0d data=%h busy=%b done=%b cnt=%0d r0=%b r1=%b",
                  bus.ram_write, bus.ram_addr, bus.ram_data, busy, done, wr_count,
                  bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      idle(2);
   endtask

   task automatic test_alternate();
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 32'h1111_0000 + i, 1'b1, 32'h2222_0000 + i);
      idle(2);
   endtask

   task automatic test_single();
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'hA0 + i, 1'b0, 32'd0);
      idle(1);
      tests++;
      if ({done, wr_count} !== {1'b1, 4'd8}) begin
         fails++;
         $display("FAIL frame_done: got done=%b cnt=%0d, want done=1 cnt=8", done, wr_count);
      end
   endtask

   task automatic test_done_hold();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hDEAD_0000 + i, 1'b1, 32'hBEEF_0000 + i);
      // start with valids high: no transfer on the start cycle
      cycle(1'b1, 1'b1, 32'hC0, 1'b1, 32'hC1);
      cycle(1'b0, 1'b1, 32'hC2, 1'b0, 32'd0);
      idle(2);
   endtask

   task automatic test_start_in_run();
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'h50, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h51);
      cycle(1'b1, 1'b1, 32'h52, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h60 + i, 1'b0, 32'd0);
      idle(2);
   endtask

   task automatic test_toggle();
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b0, 32'd0, (i % 2 == 0), 32'h7700 + i);
      idle(2);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h9900 + i);
      idle(1);
      do_reset_async();
      idle(1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'hAB00, 1'b1, 32'hCD00);
      cycle(1'b0, 1'b1, 32'hAB01, 1'b1, 32'hCD01);
      idle(2);
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_single();
      test_done_hold();
      test_start_in_run();
      test_toggle();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_writes: %0d expected writes never seen, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
